matrix_ram_loader: RTL and testbench

//  Write-side counterpart to the matrix-multiply datapath's operand fetch.

---
 rtl/matrix_ram_loader.sv | 102 ++++++++++
 tb/tb_matrix_ram_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/matrix_ram_loader.sv
// Streams an operand byte sequence into the A RAM then the B RAM, with a
// one-cycle registered write port, plus a running checksum and byte count.
module matrix_ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int A_DEPTH    = 4096,
  parameter int B_DEPTH    = 64,
  parameter int A_ADDR_W   = 12,
  parameter int B_ADDR_W   = 6
) (
  input  logic                  clock,
  input  logic                  reset_l,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  a_we,
  output logic [A_ADDR_W-1:0]   a_addr,
  output logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  b_we,
  output logic [B_ADDR_W-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum,
  output logic [15:0]           byte_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]          state;
  logic [A_ADDR_W-1:0] a_idx;
  logic [B_ADDR_W-1:0] b_idx;
  logic                xfer;

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign busy     = in_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state      <= IDLE;
      a_idx      <= '0;
      b_idx      <= '0;
      a_we       <= 1'b0;
      a_addr     <= '0;
      a_wdata    <= '0;
      b_we       <= 1'b0;
      b_addr     <= '0;
      b_wdata    <= '0;
      done       <= 1'b0;
      checksum   <= '0;
      byte_count <= '0;
    end else begin
      a_we <= 1'b0;
      b_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD_A;
            a_idx      <= '0;
            b_idx      <= '0;
            checksum   <= '0;
            byte_count <= '0;
            done       <= 1'b0;
          end
        end
        LOAD_A: begin
          if (in_valid) begin
            a_we    <= 1'b1;
            a_addr  <= a_idx;
            a_wdata <= in_data;
            a_idx   <= a_idx + A_ADDR_W'(1);
            // next byte goes straight to B address 0, no bubble
            if (a_idx == A_ADDR_W'(A_DEPTH - 1)) state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_we    <= 1'b1;
            b_addr  <= b_idx;
            b_wdata <= in_data;
            b_idx   <= b_idx + B_ADDR_W'(1);
            if (b_idx == B_ADDR_W'(B_DEPTH - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // lands in the same cycle as the write strobe for this byte
      if (xfer) begin
        checksum   <= checksum + 16'(in_data);
        byte_count <= byte_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_ram_loader.sv
// Self-checking bench: per-cycle comparison against a byte-count based model,
// plus a table of whole-load scenarios with their final checksum/count.
module tb_matrix_ram_loader;
  localparam int A_DEPTH = 4096;
  localparam int B_DEPTH = 64;
  localparam int TOTAL   = A_DEPTH + B_DEPTH;

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, a_we, b_we, busy, done;
  logic [11:0] a_addr;
  logic [5:0]  b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic [15:0] checksum, byte_count;

  matrix_ram_loader dut (
    .clock(clock), .reset_l(reset_l), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .busy(busy), .done(done), .checksum(checksum), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: loading flag, number of bytes accepted, running sum, last write.
  bit         m_busy = 0;
  bit         m_done = 0;
  int         m_n = 0;
  logic [15:0] m_sum = '0;
  bit         m_wr = 0;
  int         m_k = 0;
  logic [7:0] m_d = '0;

  typedef struct {
    int          mode;      // 0 valid always, 1 valid toggles, 2 random valid+data
    int          pulse_at;  // byte index at which a stray start is pulsed, -1 none
    bit          chk_sum;
    logic [15:0] exp_sum;
    logic [15:0] exp_cnt;
  } load_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit wa, wb;
    wa = m_wr && (m_k < A_DEPTH);
    wb = m_wr && (m_k >= A_DEPTH);
    check("in_ready", 32'(in_ready), 32'(m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("checksum", 32'(checksum), 32'(m_sum));
    check("byte_count", 32'(byte_count), m_n);
    check("a_we", 32'(a_we), 32'(wa));
    check("b_we", 32'(b_we), 32'(wb));
    if (wa) begin
      check("a_addr", 32'(a_addr), m_k);
      check("a_wdata", 32'(a_wdata), 32'(m_d));
    end else if (wb) begin
      check("b_addr", 32'(b_addr), m_k - A_DEPTH);
      check("b_wdata", 32'(b_wdata), 32'(m_d));
    end
  endtask

  task automatic cycle(input bit s, input bit v, input logic [7:0] d);
    bit xfer, st;
    start = s; in_valid = v; in_data = d;
    xfer = v && m_busy;
    st   = s && !m_busy;
    @(posedge clock); #1;
    m_wr = 0;
    if (st) begin
      m_busy = 1; m_done = 0; m_n = 0; m_sum = '0;
    end else if (xfer) begin
      m_wr = 1; m_k = m_n; m_d = d; m_n++; m_sum = m_sum + 16'(d);
      if (m_n == TOTAL) begin m_busy = 0; m_done = 1; end
    end
    start = 0;
    compare();
  endtask

  // Asserted between edges so the clear is seen without a clock edge.
  task automatic do_reset();
    #2 reset_l = 1'b0;
    #1;
    m_busy = 0; m_done = 0; m_n = 0; m_sum = '0; m_wr = 0;
    compare();
    @(negedge clock);
    reset_l = 1'b1;
  endtask

  task automatic run_load(input int mode, input int pulse_at, input int abort_at);
    int idx, guard;
    bit v;
    logic [7:0] d;
    idx = 0; guard = 0;
    cycle(1'b1, 1'b0, 8'h00);
    while (m_busy && guard < 20000) begin
      guard++;
      if (abort_at >= 0 && idx == abort_at) begin
        do_reset();
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (guard % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (mode == 2) ? 8'($urandom) : 8'(idx);
      cycle(idx == pulse_at, v, d);
      if (v) idx++;
    end
    check("load_timeout", 32'(guard < 20000), 32'd1);
    // DONE holds and ignores further bytes
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'($urandom));
  endtask

  initial begin
    load_vec_t vecs[4];
    vecs[0] = '{0, -1, 1'b1, 16'hFFE0, 16'h1040};
    vecs[1] = '{1, -1, 1'b1, 16'hFFE0, 16'h1040};
    vecs[2] = '{0, 100, 1'b1, 16'hFFE0, 16'h1040};
    vecs[3] = '{2, -1, 1'b0, 16'h0000, 16'h1040};

    #1 compare();
    @(negedge clock);
    reset_l = 1'b1;

    // Bytes offered in IDLE without start are never taken
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'hAA);
    // start with in_valid in IDLE: that byte is not accepted
    cycle(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(i));
    do_reset();

    for (int t = 0; t < 4; t++) begin
      run_load(vecs[t].mode, vecs[t].pulse_at, -1);
      check("final_done", 32'(done), 32'd1);
      check("final_count", 32'(byte_count), 32'(vecs[t].exp_cnt));
      if (vecs[t].chk_sum) check("final_checksum", 32'(checksum), 32'(vecs[t].exp_sum));
    end

    // Abort in LOAD_B, then a full reload matches a clean load
    run_load(0, -1, 4120);
    run_load(0, -1, -1);
    check("reload_checksum", 32'(checksum), 32'h0000FFE0);
    check("reload_count", 32'(byte_count), 32'h00001040);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
